// File: rtl/bg_row_loader_pkg.sv
// ============================================================================
// Module   : bg_row_loader_pkg
// Purpose  : Name-table layout constants and loader FSM state type.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package bg_row_loader_pkg;

    localparam int NT_ROW_WORDS = 8;
    localparam int NT_HALF_ROWS = 30;
    localparam int NT_ATTR_OFS  = 240;
    localparam int NT_HALF_OFS  = 256;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TILE = 2'd1,
        S_ATTR = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bg_row_loader_if.sv
// ============================================================================
// Module   : bg_row_loader_if
// Purpose  : CPU write, map ROM read and name-table write bundle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface bg_row_loader_if;
    logic        cpu_wr_req;
    logic [8:0]  cpu_wr_addr;
    logic [31:0] cpu_wr_data;
    logic        cpu_wr_ack;
    logic        map_rd_en;
    logic [11:0] map_rd_addr;
    logic [31:0] map_rd_data;
    logic        nt_we;
    logic [8:0]  nt_addr;
    logic [31:0] nt_wdata;

    modport master (
        input  cpu_wr_req, cpu_wr_addr, cpu_wr_data, map_rd_data,
        output cpu_wr_ack, map_rd_en, map_rd_addr, nt_we, nt_addr, nt_wdata
    );

    modport slave (
        output cpu_wr_req, cpu_wr_addr, cpu_wr_data, map_rd_data,
        input  cpu_wr_ack, map_rd_en, map_rd_addr, nt_we, nt_addr, nt_wdata
    );
endinterface

`default_nettype wire

// File: rtl/bg_ring_row_calc.sv
// ============================================================================
// Module   : bg_ring_row_calc
// Purpose  : Maps the current ring row to the row just above it (wrapping).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bg_ring_row_calc
    import bg_row_loader_pkg::*;
(
    input  logic [5:0] cur_row,
    output logic [5:0] dest_row
);

    localparam logic [5:0] c_HALF1_FIRST = 6'(NT_HALF_OFS / NT_ROW_WORDS);
    localparam logic [5:0] c_HALF0_LAST  = 6'(NT_HALF_ROWS - 1);
    localparam logic [5:0] c_HALF1_LAST  = c_HALF1_FIRST + c_HALF0_LAST;

    // Row 0 of each half wraps to the last row of the other half.
    always_comb begin
        if (cur_row == 6'd0)
            dest_row = c_HALF1_LAST;
        else if (cur_row == c_HALF1_FIRST)
            dest_row = c_HALF0_LAST;
        else
            dest_row = cur_row - 6'd1;
    end

endmodule

`default_nettype wire

// File: rtl/bg_row_loader.sv
// ============================================================================
// Module   : bg_row_loader
// Purpose  : Streams one map row into the name-table ring per vblank.
//            BG_ATTR_LOAD_EN adds the attribute-word load state.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bg_row_loader
    import bg_row_loader_pkg::*;
#(
    parameter int          MAP_ROWS      = 240,
    parameter logic [11:0] ATTR_MAP_BASE = 12'd1920
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              vblank_pulse,
    input  logic [8:0]        scroll_ptr,
    output logic              busy,
    output logic [8:0]        map_row,
    bg_row_loader_if.master   bus
);

`ifdef BG_ATTR_LOAD_EN
    localparam bit c_ATTR_EN = 1'b1;
`else
    localparam bit c_ATTR_EN = 1'b0;
`endif
    localparam logic [3:0] c_TILE_LAST = 4'(NT_ROW_WORDS);
    localparam logic [3:0] c_ATTR_LAST = 4'd2;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [5:0]  r_dest, r_last_row, r_pend_row;
    logic        r_pending, r_busy;
    logic [8:0]  r_map_row;

    logic [5:0]  w_samp_row, w_dest;
    logic [4:0]  w_local_row;
    logic        w_have_req, w_cpu_first, w_start, w_cpu_go, w_attr_go;
    logic        w_unused;

    assign w_unused    = ^scroll_ptr[2:0];
    assign w_samp_row  = vblank_pulse ? scroll_ptr[8:3] : r_pend_row;
    assign w_have_req  = vblank_pulse | r_pending;
    // A fresh pulse colliding with a CPU write lets the CPU go first.
    assign w_cpu_first = vblank_pulse & bus.cpu_wr_req;
    assign w_start     = (r_state == S_IDLE) && w_have_req && !w_cpu_first &&
                         (w_samp_row != r_last_row);
    assign w_cpu_go    = (r_state == S_IDLE) && bus.cpu_wr_req && !w_start;
    assign w_local_row = r_dest[4:0];
    assign w_attr_go   = c_ATTR_EN && (w_local_row[1:0] == 2'b00);

    assign busy    = r_busy;
    assign map_row = r_map_row;

    bg_ring_row_calc u_ring_row_calc (
        .cur_row  (w_samp_row),
        .dest_row (w_dest)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_dest     <= '0;
            r_last_row <= '0;
            r_pend_row <= '0;
            r_pending  <= 1'b0;
            r_busy     <= 1'b0;
            r_map_row  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (r_state == S_TILE) || (r_state == S_ATTR);
            if (w_start) begin
                r_dest     <= w_dest;
                r_last_row <= w_samp_row;
            end
            if (r_state == S_IDLE) begin
                if (w_cpu_first) begin
                    r_pending  <= 1'b1;
                    r_pend_row <= scroll_ptr[8:3];
                end else if (w_have_req) begin
                    r_pending <= 1'b0;
                end
            end else if (vblank_pulse) begin
                r_pending  <= 1'b1;
                r_pend_row <= scroll_ptr[8:3];
            end
            if (r_state == S_DONE)
                r_map_row <= (r_map_row == 9'(MAP_ROWS - 1)) ? 9'd0 : r_map_row + 9'd1;
        end
    end

    // Reads lead writes by one cycle; the write for word k uses the ROM data of read k.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        bus.cpu_wr_ack  = 1'b0;
        bus.map_rd_en   = 1'b0;
        bus.map_rd_addr = '0;
        bus.nt_we       = 1'b0;
        bus.nt_addr     = '0;
        bus.nt_wdata    = '0;
        if (rstn) begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        w_state_nxt = S_TILE;
                        w_cnt_nxt   = '0;
                    end
                    if (w_cpu_go) begin
                        bus.cpu_wr_ack = 1'b1;
                        bus.nt_we      = 1'b1;
                        bus.nt_addr    = bus.cpu_wr_addr;
                        bus.nt_wdata   = bus.cpu_wr_data;
                    end
                end
                S_TILE: begin
                    bus.map_rd_en   = (r_cnt < c_TILE_LAST);
                    bus.map_rd_addr = {r_map_row, 3'b000} + 12'(r_cnt);
                    if (r_cnt != 4'd0) begin
                        bus.nt_we    = 1'b1;
                        bus.nt_addr  = {r_dest, 3'b000} + 9'(r_cnt - 4'd1);
                        bus.nt_wdata = bus.map_rd_data;
                    end
                    if (r_cnt == c_TILE_LAST) begin
                        w_state_nxt = w_attr_go ? S_ATTR : S_DONE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
                S_ATTR: begin
                    bus.map_rd_en   = (r_cnt < c_ATTR_LAST);
                    bus.map_rd_addr = ATTR_MAP_BASE + {4'b0, r_map_row[8:2], 1'b0} + 12'(r_cnt);
                    if (r_cnt != 4'd0) begin
                        bus.nt_we    = 1'b1;
                        bus.nt_addr  = (r_dest[5] ? 9'(NT_HALF_OFS) : 9'd0) + 9'(NT_ATTR_OFS) +
                                       {5'b0, w_local_row[4:2], 1'b0} + 9'(r_cnt - 4'd1);
                        bus.nt_wdata = bus.map_rd_data;
                    end
                    if (r_cnt == c_ATTR_LAST) begin
                        w_state_nxt = S_DONE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bg_row_loader.sv
// ============================================================================
// Module   : tb_bg_row_loader
// Purpose  : Scoreboard bench for bg_row_loader name-table writes and timing.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bg_row_loader;

    localparam int c_MAP_ROWS = 6;
`ifdef BG_ATTR_LOAD_EN
    localparam bit c_ATTR = 1'b1;
`else
    localparam bit c_ATTR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    logic       vblank_pulse;
    logic [8:0] scroll_ptr;
    logic       busy;
    logic [8:0] map_row;

    bg_row_loader_if bus();

    bg_row_loader #(.MAP_ROWS(c_MAP_ROWS), .ATTR_MAP_BASE(12'd1920)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .vblank_pulse (vblank_pulse),
        .scroll_ptr   (scroll_ptr),
        .busy         (busy),
        .map_row      (map_row),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input int a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    always @(posedge clk) if (bus.map_rd_en) bus.map_rd_data <= rom(int'(bus.map_rd_addr));

    int n_pass = 0;
    int n_total = 0;
    logic [40:0] sb_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [8:0] sp);
        scroll_ptr   = sp;
        vblank_pulse = 1'b1;
        tick();
        vblank_pulse = 1'b0;
    endtask

    // Expected name-table writes of one row load; returns the busy length.
    task automatic push_load(input int m, input int dest, output int busy_len);
        int half, loc;
        for (int k = 0; k < 8; k++) sb_q.push_back({9'(dest * 8 + k), rom(m * 8 + k)});
        busy_len = 9;
        if (c_ATTR && (dest % 4 == 0)) begin
            half = (dest >= 32) ? 256 : 0;
            loc  = dest % 32;
            for (int k = 0; k < 2; k++)
                sb_q.push_back({9'(half + 240 + (loc / 4) * 2 + k), rom(1920 + (m / 4) * 2 + k)});
            busy_len = 12;
        end
    endtask

    task automatic run_load(output int busy_cyc);
        busy_cyc = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy) busy_cyc++;
            else if (busy_cyc > 0) break;
        end
    endtask

    task automatic load_case(input string name, input logic [8:0] sp, input int m,
                             input int dest, input int m_next);
        int exp_busy, got_busy;
        push_load(m, dest, exp_busy);
        pulse(sp);
        run_load(got_busy);
        check({name, "_busy_cycles"}, 64'(got_busy), 64'(exp_busy));
        check({name, "_map_row"}, 64'(map_row), 64'(m_next));
    endtask

    initial begin
        int exp_busy, got_busy, last_busy, ack_cyc, max_busy;
        logic [40:0] exp_w;

        fork
            forever begin
                @(negedge clk);
                if (bus.nt_we) begin
                    if (sb_q.size() == 0) begin
                        check("nt_write_unexpected", {23'd0, bus.nt_addr, bus.nt_wdata}, 64'd0);
                    end else begin
                        exp_w = sb_q.pop_front();
                        check("nt_write", {23'd0, bus.nt_addr, bus.nt_wdata}, {23'd0, exp_w});
                    end
                end
                if (bus.cpu_wr_ack) check("ack_while_busy", 64'(busy), 64'd0);
            end
        join_none

        rstn = 1'b0; vblank_pulse = 1'b0; scroll_ptr = '0;
        bus.cpu_wr_req = 1'b1; bus.cpu_wr_addr = 9'd7; bus.cpu_wr_data = 32'h1111_2222;
        repeat (3) tick();
        check("rst_nt_we",       64'(bus.nt_we),       64'd0);
        check("rst_map_rd_en",   64'(bus.map_rd_en),   64'd0);
        check("rst_cpu_wr_ack",  64'(bus.cpu_wr_ack),  64'd0);
        check("rst_busy",        64'(busy),            64'd0);
        check("rst_nt_addr",     64'(bus.nt_addr),     64'd0);
        check("rst_nt_wdata",    64'(bus.nt_wdata),    64'd0);
        check("rst_map_rd_addr", 64'(bus.map_rd_addr), 64'd0);
        check("rst_map_row",     64'(map_row),         64'd0);
        bus.cpu_wr_req = 1'b0;
        rstn = 1'b1;
        tick();

        // cur_row 2 from last_row 0: rows 1, map words 0..7
        load_case("row1", 9'd16, 0, 1, 1);

        // same tile row again: nothing happens
        pulse(9'd17);
        max_busy = 0;
        for (int i = 0; i < 12; i++) begin tick(); if (busy) max_busy = 1; end
        check("same_row_busy", 64'(max_busy), 64'd0);
        check("same_row_map_row", 64'(map_row), 64'd1);

        load_case("row29", 9'd256, 1, 29, 2);
        load_case("row0",  9'd8,   2, 0,  3);
        load_case("row61", 9'd0,   3, 61, 4);

        // CPU request held across a load, dest_row 4
        push_load(4, 4, exp_busy);
        sb_q.push_back({9'd300, 32'hDEAD_BEEF});
        pulse(9'd40);
        bus.cpu_wr_req = 1'b1; bus.cpu_wr_addr = 9'd300; bus.cpu_wr_data = 32'hDEAD_BEEF;
        last_busy = -1; ack_cyc = -1; got_busy = 0;
        for (int i = 1; i < 40; i++) begin
            tick();
            if (busy) begin last_busy = i; got_busy++; end
            if (bus.cpu_wr_ack) begin
                ack_cyc = i;
                tick();
                bus.cpu_wr_req = 1'b0;
                break;
            end
        end
        bus.cpu_wr_req = 1'b0;
        check("held_cpu_busy_cycles", 64'(got_busy), 64'(exp_busy));
        check("held_cpu_ack_delay", 64'(ack_cyc - last_busy), 64'd1);
        check("held_cpu_map_row", 64'(map_row), 64'd5);

        // map_row at MAP_ROWS-1 wraps to 0
        load_case("wrap", 9'd72, 5, 8, 0);

        // vblank and CPU request in the same idle cycle
        sb_q.push_back({9'd5, 32'h1234_5678});
        push_load(0, 11, exp_busy);
        bus.cpu_wr_req = 1'b1; bus.cpu_wr_addr = 9'd5; bus.cpu_wr_data = 32'h1234_5678;
        scroll_ptr = 9'd96; vblank_pulse = 1'b1;
        #1;
        check("coincide_ack", 64'(bus.cpu_wr_ack), 64'd1);
        tick();
        bus.cpu_wr_req = 1'b0; vblank_pulse = 1'b0;
        run_load(got_busy);
        check("coincide_busy_cycles", 64'(got_busy), 64'(exp_busy));
        check("coincide_map_row", 64'(map_row), 64'd1);

        // pulses during a load: last sample wins
        push_load(1, 15, exp_busy);
        push_load(2, 17, exp_busy);
        pulse(9'd128);
        tick(); tick();
        pulse(9'd136);
        pulse(9'd144);
        for (int i = 0; i < 60 && map_row != 9'd3; i++) tick();
        check("pending_map_row", 64'(map_row), 64'd3);
        repeat (3) tick();
        check("pending_idle_busy", 64'(busy), 64'd0);

        // reset at TILE k=3: only words 0 and 1 were written
        sb_q.push_back({9'd152, rom(24)});
        sb_q.push_back({9'd153, rom(25)});
        pulse(9'd160);
        tick(); tick(); tick();
        rstn = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("abort_nt_we", 64'(bus.nt_we), 64'd0);
        check("abort_map_row", 64'(map_row), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bg_row_loader.md
BG_ROW_LOADER -- requirements
Module: bg_row_loader

Interface
REQ-001 Parameter MAP_ROWS, default 240: number of tile rows in the level map ROM; the map row counter wraps at this value.
REQ-002 Parameter ATTR_MAP_BASE, default 12'd1920: map ROM word address of the first attribute word.
REQ-003 Reset rstn, synchronous, active-low; clock clk.
REQ-004 clk  in  1  system clock; rstn  in  1  synchronous active-low reset.
REQ-005 vblank_pulse  in  1  one-cycle strobe at the start of vertical blanking.
REQ-006 scroll_ptr  in  9  current scroll pointer; legal values are 0..239 and 256..495.
REQ-007 cpu_wr_req  in  1, cpu_wr_addr  in  9, cpu_wr_data  in  32: CPU name-table write request, held until acknowledged.
REQ-008 cpu_wr_ack  out  1  one-cycle acknowledge; the CPU write is performed in the same cycle.
REQ-009 map_rd_en  out  1, map_rd_addr  out  12: map ROM read; map_rd_data  in  32 is valid exactly 1 cycle after map_rd_en.
REQ-010 nt_we  out  1, nt_addr  out  9, nt_wdata  out  32: the single name-table RAM write port.
REQ-011 busy  out  1  high while a row load is in progress; map_row  out  9  next map row to load.

Function
REQ-012 Name-table layout: each half holds 30 tile rows of 8 words (4 tiles per word). Half 0 tile rows are words 0..239 and attributes are words 240..255. Half 1 tile rows are words 256..495 and attributes are words 496..511. Ring rows are therefore 0..29 and 32..61.
REQ-013 On vblank_pulse, sample cur_row = scroll_ptr[8:3]. If cur_row differs from last_row, start a load and set last_row to cur_row. If cur_row equals last_row, do nothing.
REQ-014 Destination ring row: 61 when cur_row=0; 29 when cur_row=32; otherwise cur_row-1.
REQ-015 FSM states and transitions:
- IDLE -> TILE on load start.
- TILE -> ATTR, or TILE -> DONE when ATTR is not applicable.
- ATTR -> DONE.
- DONE -> IDLE.
REQ-016 TILE is pipelined, with k=0..7:
- Cycle k: map_rd_en=1, map_rd_addr = map_row*8+k.
- Cycle k+1: nt_we=1, nt_addr = dest_row*8+k, nt_wdata = map_rd_data.
- TILE lasts 9 cycles in total.
REQ-017 In DONE, map_row increments by 1, wrapping from MAP_ROWS-1 to 0. busy deasserts on the cycle after DONE.
REQ-018 The loader owns the write port while busy. CPU requests are served only in IDLE: one write per cycle, with cpu_wr_ack=1 and nt_we=1 in the same cycle.
REQ-019 When vblank_pulse and cpu_wr_req coincide in IDLE, the CPU write completes that cycle and the load starts in the next cycle.
REQ-020 A vblank_pulse that arrives while busy sets a one-deep pending flag. The pending load starts from IDLE using the scroll_ptr sampled at that pulse; a further pulse overwrites the sample.
REQ-021 The loader never drives both requesters onto the port in one cycle. cpu_wr_ack is never asserted while busy=1.

Reset
REQ-022 Reset values:
- Outputs: nt_we=0, map_rd_en=0, cpu_wr_ack=0, busy=0, nt_addr=0, nt_wdata=0, map_rd_addr=0, map_row=0.
- Internal: last_row=0, pending=0, FSM in IDLE.
REQ-023 Reset asserted mid-load aborts the load with no further writes. map_row is not advanced beyond its reset value.

Configuration
REQ-024 Macro BG_ATTR_LOAD_EN enables the ATTR state.
- With the macro defined: when local row (dest_row mod 32) mod 4 == 0, ATTR performs 2 pipelined words (3 cycles).
- ATTR source address: ATTR_MAP_BASE + (map_row>>2)*2 + k.
- ATTR destination address: half base + 240 + local_row[4:2]*2 + k.
- Without the macro: TILE -> DONE always, and attribute words are written only by the CPU.

Structure
REQ-025 A shared package holds:
- Layout constants NT_ROW_WORDS=8, NT_HALF_ROWS=30, NT_ATTR_OFS=240, NT_HALF_OFS=256.
- The FSM state enum.
REQ-026 One sub-module, bg_ring_row_calc, is used. It is combinational: cur_row in, dest_row out, and it implements REQ-014.

Verification
REQ-027 scroll_ptr=16, last_row=0, vblank_pulse -> 8 writes to nt_addr 8..15, data from map words 0..7, busy for 9 cycles, map_row becomes 1.
REQ-028 scroll_ptr=256 (cur_row 32), vblank_pulse -> writes land at nt_addr 232..239 (row 29).
REQ-029 scroll_ptr=0 from last_row 1, vblank_pulse -> writes land at nt_addr 488..495 (row 61).
REQ-030 cpu_wr_req held during a load -> cpu_wr_ack occurs exactly 1 cycle after busy falls; no cycle has two writers.
REQ-031 map_row=MAP_ROWS-1 load -> map_row wraps to 0; with BG_ATTR_LOAD_EN and dest_row=4, 2 extra writes go to nt_addr 242..243.
REQ-032 rstn pulled low at TILE k=3 -> nt_we stays 0 thereafter and map_row=0.
